fir_tap_sequencer: RTL and testbench
====================================

Name: fir_tap_sequencer

Overview:
- Time-multiplexed FIR engine that sits directly around the shared 16x16 unsigned approximate multiplier.
- Upstream side: it feeds the multiplier operand magnitudes taken from a sample delay line and a coefficient bank.
- Downstream side: it consumes the 32-bit unsigned product, restores the sign and accumulates one output per input sample.
- The multiplier itself stays external; it connects through mul_a/mul_b/mul_r.

Parameters:
- TAPS, 8, number of filter taps (2..32).
- IDX_W, clog2(TAPS), tap index width.
- ACC_W, 33+IDX_W, signed accumulator/output width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  16  signed two's-complement sample.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  IDX_W  coefficient index.
- coef_data  in  16  signed coefficient.
- coef_err  out  1  one-cycle pulse: write dropped while busy.
- mul_a  out  16  multiplier operand A, sample magnitude.
- mul_b  out  16  multiplier operand B, coefficient magnitude.
- mul_r  in  32  unsigned product from the multiplier, combinational on mul_a/mul_b.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed filter output.

Behaviour:
- Reset, synchronous, wins over everything:
  - state=IDLE; delay line, coefficient bank, accumulator, product register and out_data all 0.
  - out_valid=0, coef_err=0, mul_a=mul_b=0.
- Reset mid-operation aborts the computation. No output is produced.
- FSM states: IDLE, MAC, FLUSH, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, shift the delay line: x[0]<=in_data, x[k]<=x[k-1]. Then clear acc, set idx=0 and go to MAC.
- MAC, TAPS cycles, idx 0..TAPS-1:
  - Drive mul_a=|x[idx]| and mul_b=|c[idx]|.
  - Register mul_r into prod and neg<=sign(x[idx])^sign(c[idx]).
  - From the second MAC cycle, acc<=acc+(neg?-prod:prod) using the previous cycle's prod.
  - After idx=TAPS-1, go to FLUSH.
- FLUSH, 1 cycle: accumulate the last prod, then go to OUT.
- OUT:
  - out_valid=1 and out_data=acc, both held stable until out_ready.
  - On out_valid&&out_ready, return to IDLE; in_ready rises the next cycle.
- Latency: acceptance at cycle t gives out_valid at t+TAPS+2. Minimum throughput is one sample per TAPS+3 cycles.
- in_ready=0 in MAC/FLUSH/OUT. in_valid there is ignored and the sample is not consumed.
- Magnitude rules:
  - |v| = v[15] ? -v : v, taken as 16-bit unsigned.
  - -32768 maps to 32768 (0x8000); no overflow.
  - Products are zero-extended to ACC_W before the conditional negate.
  - The accumulator cannot overflow by construction of ACC_W.
- Zero operand: if either magnitude is 0, force neg=0 so no -0 contribution appears.
- mul_a/mul_b are 0 outside MAC.
- Coefficient writes:
  - Accepted only in IDLE and take effect next cycle.
  - A write in IDLE coinciding with in_valid applies before the MAC begins.
  - A write in any other state is dropped and coef_err pulses for 1 cycle.
  - coef_addr>=TAPS is dropped silently.
- Product error from the approximate multiplier is passed through uncorrected. The block is bit-exact relative to mul_r.

Decomposition:
- Shared package fir_pkg:
  - FSM state enum (IDLE, MAC, FLUSH, OUT).
  - SAMPLE_W=16, PROD_W=32.
  - A function for the sign-magnitude split.
- One natural sub-module: fir_coef_bank, a TAPS x 16 register file with gated write, a combinational read port and the error pulse.
- The delay line and FSM stay in the top.

Test Plan:
- The multiplier is exact for magnitudes below 64; directed tests use such values. A bench model of the external multiplier is used for the rest.
- Impulse: TAPS=4, coefs 1,2,3,4; samples 1,0,0,0,0 -> outputs 1,2,3,4,0, each out_valid exactly 6 cycles after acceptance.
- Signs: coef c0=-3, others 0; samples 5 then -7 -> outputs -15 then 21; sample 0 -> 0 with no -0 artifact.
- Extremes: c0=-32768, x=-32768 -> mul_a=mul_b=0x8000, out_data=+1073741824.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0, and an in_valid pulse in that window is not consumed. Releasing out_ready returns to IDLE.
- Coefficient write during MAC -> coef_err pulses 1 cycle, bank unchanged, result equals the pre-write coefficients. A write to addr>=TAPS has no effect.
- Reset asserted in MAC cycle 2 -> next cycle IDLE, in_ready=1, out_valid=0, and a subsequent impulse yields an all-zero response because coefficients were cleared.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR tap sequencer.
// Holds the FSM state encoding, datapath widths and the sign-magnitude split.
package fir_pkg;

  localparam int SAMPLE_W = 16;
  localparam int PROD_W   = 32;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    FLUSH,
    OUT
  } state_t;

  typedef struct packed {
    logic                sign;
    logic [SAMPLE_W-1:0] mag;
  } sm_t;

  // The most negative value maps to 0x8000, which still fits as an unsigned magnitude.
  function automatic sm_t sm_split(input logic [SAMPLE_W-1:0] v);
    sm_t r;
    r.sign = v[SAMPLE_W-1];
    r.mag  = v[SAMPLE_W-1] ? (~v + SAMPLE_W'(1)) : v;
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// TAPS x 16 coefficient register file with a write port gated to the idle state,
// a combinational read port for the tap loop, and a one-cycle dropped-write pulse.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_allow,
  input  logic                we,
  input  logic [IDX_W-1:0]    addr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [SAMPLE_W-1:0] rdata,
  output logic                err
);

  logic [SAMPLE_W-1:0] coef [TAPS];

  // NOTE: the bank is a small flop array, so it is reset explicitly; a cleared bank is part of the reset contract.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) coef[k] <= '0;
      err <= 1'b0;
    end else begin
      err <= we && !wr_allow;
      if (we && wr_allow && (int'(addr) < TAPS)) coef[addr] <= wdata;
    end
  end

  assign rdata = coef[raddr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexed FIR engine wrapped around an external 16x16 unsigned multiplier:
// feeds operand magnitudes out, restores the sign of each product and accumulates one output per sample.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int IDX_W = $clog2(TAPS),
  parameter int ACC_W = 33 + IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SAMPLE_W-1:0]     in_data,
  input  logic                    coef_we,
  input  logic [IDX_W-1:0]        coef_addr,
  input  logic [SAMPLE_W-1:0]     coef_data,
  output logic                    coef_err,
  output logic [SAMPLE_W-1:0]     mul_a,
  output logic [SAMPLE_W-1:0]     mul_b,
  input  logic [PROD_W-1:0]       mul_r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data
);

  state_t                  state, state_nxt;
  logic [SAMPLE_W-1:0]     x [TAPS];
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic [PROD_W-1:0]       prod;
  logic                    neg;
  logic [SAMPLE_W-1:0]     coef_rd;
  sm_t                     x_sm, c_sm;
  logic signed [ACC_W-1:0] prod_ext, term, acc_sum;
  logic                    last_tap;

  fir_coef_bank #(.TAPS(TAPS), .IDX_W(IDX_W)) u_coef_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_allow (state == IDLE),
    .we       (coef_we),
    .addr     (coef_addr),
    .wdata    (coef_data),
    .raddr    (idx),
    .rdata    (coef_rd),
    .err      (coef_err)
  );

  assign last_tap = (idx == IDX_W'(TAPS - 1));
  assign x_sm     = sm_split(x[idx]);
  assign c_sm     = sm_split(coef_rd);
  assign prod_ext = signed'({{(ACC_W - PROD_W){1'b0}}, prod});
  assign term     = neg ? -prod_ext : prod_ext;
  assign acc_sum  = acc + term;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (last_tap) state_nxt = FLUSH;
      FLUSH:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      MAC: begin
        mul_a = x_sm.mag;
        mul_b = c_sm.mag;
      end
      OUT:     out_valid = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so the delay-line shift reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) x[k] <= '0;
      idx      <= '0;
      acc      <= '0;
      prod     <= '0;
      neg      <= 1'b0;
      out_data <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          x[0] <= in_data;
          for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
          acc <= '0;
          idx <= '0;
        end
        MAC: begin
          prod <= mul_r;
          // A zero magnitude never carries a sign, so no -0 term enters the sum.
          neg  <= (x_sm.sign ^ c_sm.sign) && (x_sm.mag != '0) && (c_sm.mag != '0);
          if (idx != '0) acc <= acc_sum;
          if (!last_tap) idx <= idx + IDX_W'(1);
        end
        FLUSH: begin
          acc      <= acc_sum;
          out_data <= acc_sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer: a 4-tap instance for the main features and a
// 5-tap instance for out-of-range coefficient addresses; the multiplier is modelled exactly.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // 4-tap instance
  logic               in_valid, in_ready, coef_we, coef_err, out_valid, out_ready;
  logic [15:0]        in_data, coef_data, mul_a, mul_b;
  logic [1:0]         coef_addr;
  logic [31:0]        mul_r;
  logic signed [34:0] out_data;

  assign mul_r = {16'b0, mul_a} * {16'b0, mul_b};

  fir_tap_sequencer #(.TAPS(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .coef_err(coef_err),
    .mul_a(mul_a), .mul_b(mul_b), .mul_r(mul_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // 5-tap instance
  logic               p5_in_valid, p5_in_ready, p5_coef_we, p5_coef_err, p5_out_valid;
  logic [15:0]        p5_in_data, p5_coef_data, p5_mul_a, p5_mul_b;
  logic [2:0]         p5_coef_addr;
  logic [31:0]        p5_mul_r;
  logic signed [35:0] p5_out_data;

  assign p5_mul_r = {16'b0, p5_mul_a} * {16'b0, p5_mul_b};

  fir_tap_sequencer #(.TAPS(5)) u_dut5 (
    .clk(clk), .rst(rst), .in_valid(p5_in_valid), .in_ready(p5_in_ready), .in_data(p5_in_data),
    .coef_we(p5_coef_we), .coef_addr(p5_coef_addr), .coef_data(p5_coef_data), .coef_err(p5_coef_err),
    .mul_a(p5_mul_a), .mul_b(p5_mul_b), .mul_r(p5_mul_r),
    .out_valid(p5_out_valid), .out_ready(1'b1), .out_data(p5_out_data)
  );

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr_coef(input logic [1:0] a, input logic [15:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat counts edges after the accept edge.
  task automatic wait_out(output logic signed [34:0] y, output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL wait_out: out_valid never rose within %0d cycles", lat);
    end
    y = out_data;
  endtask

  task automatic accept(input logic [15:0] s);
    in_valid = 1'b1; in_data = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_sample(input logic [15:0] s, output logic signed [34:0] y, output int lat);
    accept(s);
    wait_out(y, lat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL reset_coef_err: got %b want 0", coef_err); end
    n_checks++; if ({mul_a, mul_b} !== 32'h0) begin n_fail++; $display("FAIL reset_mul: got %h/%h want 0/0", mul_a, mul_b); end
    n_checks++; if (out_data !== 35'sd0) begin n_fail++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
  endtask

  task automatic test_impulse();
    logic signed [34:0] y;
    int lat;
    int exp_y [5] = '{1, 2, 3, 4, 0};
    do_reset();
    for (int k = 0; k < 4; k++) wr_coef(2'(k), 16'(k + 1));
    for (int k = 0; k < 5; k++) begin
      run_sample((k == 0) ? 16'd1 : 16'd0, y, lat);
      n_checks++; if (y !== 35'(exp_y[k])) begin n_fail++; $display("FAIL impulse_y%0d: got %0d want %0d", k, y, exp_y[k]); end
      // out_valid shows up 6 cycles after the accept cycle, i.e. 5 edges after the accept edge.
      n_checks++; if (lat != 5) begin n_fail++; $display("FAIL impulse_lat%0d: got %0d want 5", k, lat); end
    end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL impulse_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_signs();
    logic signed [34:0] y;
    int lat;
    do_reset();
    wr_coef(2'd0, 16'hFFFD);
    run_sample(16'd5, y, lat);
    n_checks++; if (y !== -35'sd15) begin n_fail++; $display("FAIL signs_pos: got %0d want -15", y); end
    run_sample(16'hFFF9, y, lat);
    n_checks++; if (y !== 35'sd21) begin n_fail++; $display("FAIL signs_neg: got %0d want 21", y); end
    run_sample(16'd0, y, lat);
    n_checks++; if (y !== 35'sd0) begin n_fail++; $display("FAIL signs_zero: got %0d want 0", y); end
  endtask

  task automatic test_extremes();
    logic signed [34:0] y;
    int lat;
    do_reset();
    wr_coef(2'd0, 16'h8000);
    accept(16'h8000);
    n_checks++; if ({mul_a, mul_b} !== {16'h8000, 16'h8000}) begin n_fail++; $display("FAIL extreme_mul: got %h/%h want 8000/8000", mul_a, mul_b); end
    wait_out(y, lat);
    n_checks++; if (y !== 35'sd1073741824) begin n_fail++; $display("FAIL extreme_y: got %0d want 1073741824", y); end
    n_checks++; if ({mul_a, mul_b} !== 32'h0) begin n_fail++; $display("FAIL extreme_mul_idle: got %h/%h want 0/0", mul_a, mul_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic signed [34:0] y;
    int lat;
    do_reset();
    wr_coef(2'd0, 16'd1);
    wr_coef(2'd1, 16'd10);
    out_ready = 1'b0;
    accept(16'd2);
    wait_out(y, lat);
    n_checks++; if (y !== 35'sd2) begin n_fail++; $display("FAIL bp_y: got %0d want 2", y); end
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 3); in_data = 16'd9;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 35'sd2 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b d=%0d rdy=%b want v=1 d=2 rdy=0", c, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    // 3*1 + 2*10: the ignored sample 9 must not appear in the delay line.
    run_sample(16'd3, y, lat);
    n_checks++; if (y !== 35'sd23) begin n_fail++; $display("FAIL bp_next: got %0d want 23", y); end
  endtask

  task automatic test_coef_err();
    logic signed [34:0] y;
    int lat;
    do_reset();
    wr_coef(2'd0, 16'd1);
    wr_coef(2'd1, 16'd2);
    n_checks++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL cerr_idle: got %b want 0", coef_err); end
    accept(16'd4);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'd50;
    @(posedge clk); #1;
    coef_we = 1'b0;
    n_checks++; if (coef_err !== 1'b1) begin n_fail++; $display("FAIL cerr_pulse: got %b want 1", coef_err); end
    @(posedge clk); #1;
    n_checks++; if (coef_err !== 1'b0) begin n_fail++; $display("FAIL cerr_width: got %b want 0", coef_err); end
    wait_out(y, lat);
    n_checks++; if (y !== 35'sd4) begin n_fail++; $display("FAIL cerr_y: got %0d want 4", y); end
    @(posedge clk); #1;
    run_sample(16'd1, y, lat);
    n_checks++; if (y !== 35'sd9) begin n_fail++; $display("FAIL cerr_bank: got %0d want 9", y); end
  endtask

  task automatic test_reset_mid();
    logic signed [34:0] y;
    int lat;
    int seen;
    do_reset();
    for (int k = 0; k < 4; k++) wr_coef(2'(k), 16'(k + 1));
    accept(16'd7);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_state: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    n_checks++; if (mul_a !== 16'h0) begin n_fail++; $display("FAIL rmid_mul_a: got %h want 0", mul_a); end
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rmid_no_out: got %0d valid cycles want 0", seen); end
    for (int k = 0; k < 4; k++) begin
      run_sample((k == 0) ? 16'd1 : 16'd0, y, lat);
      n_checks++; if (y !== 35'sd0) begin n_fail++; $display("FAIL rmid_y%0d: got %0d want 0", k, y); end
    end
  endtask

  task automatic test_addr_range();
    int exp_y [5] = '{1, 3, 6, 10, 15};
    int lat;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      p5_coef_we = 1'b1; p5_coef_addr = 3'(k);
      p5_coef_data = (k < 5) ? 16'(k + 1) : 16'h0100;
      @(posedge clk); #1;
    end
    p5_coef_we = 1'b0;
    for (int s = 0; s < 5; s++) begin
      p5_in_valid = 1'b1; p5_in_data = 16'd1;
      @(posedge clk); #1;
      p5_in_valid = 1'b0;
      lat = 0;
      while (!p5_out_valid && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      n_checks++;
      if (p5_out_data !== 36'(exp_y[s])) begin
        n_fail++;
        $display("FAIL addr_range_y%0d: got %0d want %0d (valid=%b)", s, p5_out_data, exp_y[s], p5_out_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    out_ready = 1'b1;
    p5_in_valid = 1'b0; p5_in_data = '0; p5_coef_we = 1'b0; p5_coef_addr = '0; p5_coef_data = '0;
    test_reset();
    test_impulse();
    test_signs();
    test_extremes();
    test_backpressure();
    test_coef_err();
    test_reset_mid();
    test_addr_range();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
